// File: rtl/board_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | board_pkg: cell word layout, board geometry and reveal FSM states          |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package board_pkg;

  localparam int MAX_SIZE_DEF = 16;
  localparam int ROW_W        = $clog2(MAX_SIZE_DEF);
  localparam int COL_W        = ROW_W;
  localparam int ADR_W        = ROW_W + COL_W;

  localparam int CELL_REVEALED = 7;
  localparam int CELL_FLAGGED  = 6;
  localparam int CELL_MINE     = 5;
  localparam logic [7:0] REVEALED_MASK = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_START = 3'd1,
    ST_WR_START = 3'd2,
    ST_POP      = 3'd3,
    ST_NB_SEL   = 3'd4,
    ST_NB_RD    = 3'd5,
    ST_NB_WR    = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  // Neighbour scan order: row-major over the 3x3 window, centre excluded.
  // Offsets are 2-bit two's complement (-1 = 2'b11).
  function automatic logic [1:0] nb_drow(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return 2'b11;
      3'd3, 3'd4:       return 2'b00;
      default:          return 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] nb_dcol(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd3, 3'd5: return 2'b11;
      3'd1, 3'd6:       return 2'b00;
      default:          return 2'b01;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_reveal_ctrl_lifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reveal_lifo: cell-address stack with synchronous push/pop and full/empty   |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module reveal_lifo #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic [AW-1:0]    w_top;

  assign empty = (r_cnt == '0);
  assign full  = (r_cnt == CNT_W'(DEPTH));
  assign w_top = AW'(r_cnt - 1'b1);
  assign dout  = r_mem[w_top];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (push && !full) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (pop && !empty) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage needs no reset; the counter alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      r_mem[AW'(r_cnt)] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/board_reveal_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | board_reveal_ctrl: flood-fill reveal sequencer, Wishbone master on board   |
// | memory. rev 1.0                                                            |
// +----------------------------------------------------------------------------+
module board_reveal_ctrl
  import board_pkg::*;
#(
  parameter int MAX_SIZE    = MAX_SIZE_DEF,
  parameter int STACK_DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ROW_W-1:0] start_row,
  input  logic [COL_W-1:0] start_col,
  input  logic [ROW_W:0]   board_size,
  output logic             busy,
  output logic             done,
  output logic             mine_hit,
  output logic [8:0]       revealed_cnt,
  output logic             overflow,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic [7:0]       wb_dat_o,
  input  logic [7:0]       wb_dat_i,
  input  logic             wb_ack_i
);

  localparam logic [ROW_W:0] SIZE_LIMIT = (ROW_W + 1)'(MAX_SIZE);

  state_t           r_state, w_state_nxt;
  logic [ROW_W-1:0] r_cur_row;
  logic [COL_W-1:0] r_cur_col;
  logic [ROW_W:0]   r_size;
  logic [2:0]       r_nb_idx;
  logic [7:0]       r_word;
  logic [8:0]       r_cnt;
  logic             r_gap, r_mine, r_ovf;

  logic             w_acc, w_we, w_accept, w_ld_word, w_inc_cnt;
  logic             w_push, w_pop, w_nb_clr, w_nb_inc, w_set_gap, w_set_mine;
  logic [ADR_W-1:0] w_adr, w_push_adr, w_cur_adr, w_nb_adr, w_lifo_dout;
  logic             w_lifo_empty, w_lifo_full;
  logic [1:0]       w_dr, w_dc;
  logic [ROW_W:0]   w_nb_row;
  logic [COL_W:0]   w_nb_col;
  logic             w_nb_ok;

  // Off-board offsets land at -1 (all ones) or >= size, so one unsigned
  // compare against the active edge rejects both sides without wrapping.
  assign w_dr      = nb_drow(r_nb_idx);
  assign w_dc      = nb_dcol(r_nb_idx);
  assign w_nb_row  = {1'b0, r_cur_row} + {{(ROW_W-1){w_dr[1]}}, w_dr};
  assign w_nb_col  = {1'b0, r_cur_col} + {{(COL_W-1){w_dc[1]}}, w_dc};
  assign w_nb_ok   = (w_nb_row < r_size) && (w_nb_col < r_size);
  assign w_nb_adr  = {w_nb_row[ROW_W-1:0], w_nb_col[COL_W-1:0]};
  assign w_cur_adr = {r_cur_row, r_cur_col};

  assign wb_cyc_o     = w_acc;
  assign wb_stb_o     = w_acc;
  assign wb_we_o      = w_acc && w_we;
  assign wb_adr_o     = w_adr;
  assign wb_dat_o     = w_we ? (r_word | REVEALED_MASK) : 8'h00;
  assign revealed_cnt = r_cnt;
  assign overflow     = r_ovf;

  reveal_lifo #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADR_W)
  ) u_lifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_push_adr),
    .dout  (w_lifo_dout),
    .empty (w_lifo_empty),
    .full  (w_lifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    mine_hit    = 1'b0;
    w_acc       = 1'b0;
    w_we        = 1'b0;
    w_adr       = '0;
    w_accept    = 1'b0;
    w_ld_word   = 1'b0;
    w_inc_cnt   = 1'b0;
    w_push      = 1'b0;
    w_push_adr  = w_nb_adr;
    w_pop       = 1'b0;
    w_nb_clr    = 1'b0;
    w_nb_inc    = 1'b0;
    w_set_gap   = 1'b0;
    w_set_mine  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RD_START;
        end
      end
      ST_RD_START: begin
        w_acc = !r_gap;
        w_adr = w_cur_adr;
        if (w_acc && wb_ack_i) begin
          w_ld_word = 1'b1;
          if (wb_dat_i[CELL_REVEALED] || wb_dat_i[CELL_FLAGGED]) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_set_gap   = 1'b1;
            w_state_nxt = ST_WR_START;
          end
        end
      end
      ST_WR_START: begin
        w_acc = !r_gap;
        w_we  = 1'b1;
        w_adr = w_cur_adr;
        if (w_acc && wb_ack_i) begin
          w_inc_cnt = 1'b1;
          if (r_word[CELL_MINE]) begin
            w_set_mine  = 1'b1;
            w_state_nxt = ST_DONE;
          end else if (r_word[3:0] == 4'd0) begin
            w_push      = 1'b1;
            w_push_adr  = w_cur_adr;
            w_state_nxt = ST_POP;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_POP: begin
        if (w_lifo_empty) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_pop       = 1'b1;
          w_nb_clr    = 1'b1;
          w_state_nxt = ST_NB_SEL;
        end
      end
      ST_NB_SEL: begin
        if (w_nb_ok) begin
          w_state_nxt = ST_NB_RD;
        end else if (r_nb_idx == 3'd7) begin
          w_state_nxt = ST_POP;
        end else begin
          w_nb_inc = 1'b1;
        end
      end
      ST_NB_RD: begin
        w_acc = !r_gap;
        w_adr = w_nb_adr;
        if (w_acc && wb_ack_i) begin
          w_ld_word = 1'b1;
          if (wb_dat_i[CELL_REVEALED] || wb_dat_i[CELL_FLAGGED] || wb_dat_i[CELL_MINE]) begin
            if (r_nb_idx == 3'd7) begin
              w_state_nxt = ST_POP;
            end else begin
              w_nb_inc    = 1'b1;
              w_state_nxt = ST_NB_SEL;
            end
          end else begin
            w_set_gap   = 1'b1;
            w_state_nxt = ST_NB_WR;
          end
        end
      end
      ST_NB_WR: begin
        w_acc = !r_gap;
        w_we  = 1'b1;
        w_adr = w_nb_adr;
        if (w_acc && wb_ack_i) begin
          w_inc_cnt = 1'b1;
          w_push    = (r_word[3:0] == 4'd0);
          if (r_nb_idx == 3'd7) begin
            w_state_nxt = ST_POP;
          end else begin
            w_nb_inc    = 1'b1;
            w_state_nxt = ST_NB_SEL;
          end
        end
      end
      ST_DONE: begin
        busy        = 1'b0;
        done        = 1'b1;
        mine_hit    = r_mine;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // r_gap idles the bus for one cycle between a read and its write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_row <= '0;
      r_cur_col <= '0;
      r_size    <= '0;
      r_nb_idx  <= '0;
      r_word    <= '0;
      r_cnt     <= '0;
      r_gap     <= 1'b0;
      r_mine    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_gap <= w_set_gap;
      if (w_accept) begin
        r_cur_row <= start_row;
        r_cur_col <= start_col;
        r_size    <= (board_size > SIZE_LIMIT) ? SIZE_LIMIT : board_size;
        r_cnt     <= '0;
        r_mine    <= 1'b0;
        r_ovf     <= 1'b0;
      end
      if (w_pop) begin
        {r_cur_row, r_cur_col} <= w_lifo_dout;
      end
      if (w_nb_clr) begin
        r_nb_idx <= '0;
      end else if (w_nb_inc) begin
        r_nb_idx <= r_nb_idx + 1'b1;
      end
      if (w_ld_word) begin
        r_word <= wb_dat_i;
      end
      if (w_inc_cnt) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_set_mine) begin
        r_mine <= 1'b1;
      end
      if (w_push && w_lifo_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
